// File: rtl/dma_arb_pkg.sv
// dma_arb_pkg: shared FSM state type and default parameters for the stream arbiter
package dma_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  localparam int N_REQ_D = 5;
  localparam int DATA_W_D = 256;
  localparam int MAX_BURST_D = 256;
  localparam int TIMEOUT_D = 1023;
  localparam logic [15:0] DROP_MAX = 16'hFFFF;
endpackage

// File: rtl/dma_stream_arbiter_if.sv
// dma_stream_arbiter_if: requester-side and fifo-side signals of the stream arbiter
interface dma_stream_arbiter_if import dma_arb_pkg::*; #(
  parameter int N_REQ = N_REQ_D,
  parameter int DATA_W = DATA_W_D
) ();
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ*DATA_W-1:0] in_fifo_data;
  logic [N_REQ-1:0] in_fifo_write;
  logic [N_REQ-1:0] in_fifo_send;
  logic [DATA_W-1:0] out_fifo_data;
  logic out_fifo_write;
  logic out_fifo_send;
  logic out_fifo_almost_full;
  logic [2:0] active_idx;
  logic [15:0] drop_cnt;
  logic timeout_flag;
  modport master (
    output req, in_fifo_data, in_fifo_write, in_fifo_send, out_fifo_almost_full,
    input gnt, out_fifo_data, out_fifo_write, out_fifo_send, active_idx, drop_cnt, timeout_flag
  );
  modport slave (
    input req, in_fifo_data, in_fifo_write, in_fifo_send, out_fifo_almost_full,
    output gnt, out_fifo_data, out_fifo_write, out_fifo_send, active_idx, drop_cnt, timeout_flag
  );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker searching from last+1 with wrap-around
module rr_pick #(
  parameter int N_REQ = 5
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       last,
  output logic [N_REQ-1:0] onehot,
  output logic [2:0]       idx,
  output logic             any
);
  logic [2:0] c;
  always_comb begin
    idx = '0;
    c = '0;
    // walk farthest-first so the nearest requester after last wins
    for (int k = N_REQ; k >= 1; k--) begin
      c = 3'((32'(last) + 32'(k)) % 32'(N_REQ));
      idx = req[c] ? c : idx;
    end
    any = |req;
    onehot = any ? N_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/dma_stream_arbiter.sv
// dma_stream_arbiter: round-robin burst arbiter sharing one fifo_stream write port
module dma_stream_arbiter import dma_arb_pkg::*; #(
  parameter int N_REQ = N_REQ_D,
  parameter int DATA_W = DATA_W_D,
  parameter int MAX_BURST = MAX_BURST_D,
  parameter int TIMEOUT = TIMEOUT_D
) (
  input logic clk_clk,
  input logic reset_reset,
  dma_stream_arbiter_if.slave bus
);
  localparam int WCW = $clog2(MAX_BURST + 1);
  localparam int ICW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic [N_REQ-1:0] gnt, gnt_n, p_onehot;
  logic [2:0] idx, idx_n, last, last_n, p_idx;
  logic [WCW-1:0] wcnt, wcnt_n;
  logic [ICW-1:0] icnt, icnt_n;
  logic [DATA_W-1:0] odata, odata_n;
  logic owrite, owrite_n, osend, osend_n, tflag, tflag_n, p_any;
  logic w, s, r, hit_max, to, rel;
  logic [15:0] drops, drops_n;
  logic [16:0] drop_sum;
  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req(bus.req), .last(last), .onehot(p_onehot), .idx(p_idx), .any(p_any)
  );
  assign w = bus.in_fifo_write[idx];
  assign s = bus.in_fifo_send[idx];
  assign r = bus.req[idx];
  assign hit_max = w && wcnt == WCW'(MAX_BURST - 1);
  assign to = !w && icnt == ICW'(TIMEOUT);
  // every release reason emits exactly one send, so the send and the release coincide
  assign rel = s || hit_max || to || !r;
  assign drop_sum = {1'b0, drops} + 17'($countones(bus.in_fifo_write & ~gnt));
  assign drops_n = drop_sum[16] ? DROP_MAX : drop_sum[15:0];
  always_comb begin
    state_n = state;
    gnt_n = gnt;
    idx_n = idx;
    last_n = last;
    wcnt_n = wcnt;
    icnt_n = icnt;
    odata_n = odata;
    owrite_n = 1'b0;
    osend_n = 1'b0;
    tflag_n = tflag;
    case (state)
      IDLE: if (p_any && !bus.out_fifo_almost_full) begin
        gnt_n = p_onehot;
        idx_n = p_idx;
        wcnt_n = '0;
        icnt_n = '0;
        state_n = GRANT;
      end
      GRANT: begin
        owrite_n = w;
        osend_n = rel;
        odata_n = w ? bus.in_fifo_data[int'(idx)*DATA_W +: DATA_W] : odata;
        wcnt_n = wcnt + WCW'(w);
        icnt_n = w ? '0 : icnt + 1'b1;
        tflag_n = tflag || to;
        gnt_n = rel ? '0 : gnt;
        state_n = rel ? RELEASE : GRANT;
      end
      RELEASE: begin
        last_n = idx;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_clk or posedge reset_reset)
    if (reset_reset) begin
      state <= IDLE;
      gnt <= '0;
      idx <= '0;
      last <= 3'(N_REQ - 1);
      wcnt <= '0;
      icnt <= '0;
      odata <= '0;
      owrite <= 1'b0;
      osend <= 1'b0;
      tflag <= 1'b0;
      drops <= '0;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      idx <= idx_n;
      last <= last_n;
      wcnt <= wcnt_n;
      icnt <= icnt_n;
      odata <= odata_n;
      owrite <= owrite_n;
      osend <= osend_n;
      tflag <= tflag_n;
      drops <= drops_n;
    end
  assign bus.gnt = gnt;
  assign bus.active_idx = idx;
  assign bus.out_fifo_data = odata;
  assign bus.out_fifo_write = owrite;
  assign bus.out_fifo_send = osend;
  assign bus.drop_cnt = drops;
  assign bus.timeout_flag = tflag;
endmodule

// File: tb/tb_dma_stream_arbiter.sv
// tb_dma_stream_arbiter: scoreboard bench for the round-robin stream arbiter
module tb_dma_stream_arbiter;
  localparam int N = 5;
  localparam int DW = 256;
  localparam int MB = 256;
  localparam int TO = 1023;
  typedef struct {logic [DW-1:0] d; logic w; logic s;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sbq[$];
  exp_t me;
  int vectors = 0;
  int fails = 0;
  always #5 clk = ~clk;
  dma_stream_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();
  dma_stream_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .clk_clk(clk), .reset_reset(rst), .bus(bus)
  );
  function automatic logic [DW-1:0] word(int i, int k);
    return {32'(i), 32'(k), {6{32'hA5A5_0000 + 32'(k)}}};
  endfunction
  task automatic push(logic [DW-1:0] d, logic w, logic s);
    exp_t e;
    e.d = d;
    e.w = w;
    e.s = s;
    sbq.push_back(e);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (!rst && (bus.out_fifo_write || bus.out_fifo_send)) begin
      vectors++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got write=%b send=%b, required no output", bus.out_fifo_write, bus.out_fifo_send);
      end else begin
        me = sbq.pop_front();
        if (bus.out_fifo_write !== me.w || bus.out_fifo_send !== me.s || (me.w && bus.out_fifo_data !== me.d)) begin
          fails++;
          $display("FAIL sb_word: got w=%b s=%b d=%h, required w=%b s=%b d=%h", bus.out_fifo_write, bus.out_fifo_send, bus.out_fifo_data, me.w, me.s, me.d);
        end
      end
    end
  task automatic test_reset();
    repeat (3) step();
    vectors++;
    if ({bus.gnt, bus.out_fifo_write, bus.out_fifo_send, bus.active_idx, bus.drop_cnt, bus.timeout_flag, bus.out_fifo_data} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got gnt=%b w=%b s=%b idx=%0d drop=%0d tf=%b, required all 0", bus.gnt, bus.out_fifo_write, bus.out_fifo_send, bus.active_idx, bus.drop_cnt, bus.timeout_flag);
    end
    rst = 1'b0;
    repeat (2) step();
    vectors++;
    if (bus.gnt !== '0 || bus.out_fifo_send !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got gnt=%b send=%b, required 0 0", bus.gnt, bus.out_fifo_send);
    end
  endtask
  task automatic test_round_robin();
    int e, dead;
    bus.req = '1;
    for (int j = 0; j < 6; j++) begin
      e = j % N;
      dead = 0;
      while (bus.gnt == '0 && dead < 20) begin
        step();
        dead++;
      end
      if (j > 0) begin
        vectors++;
        if (dead !== 2) begin
          fails++;
          $display("FAIL rr_dead: got %0d dead cycles, required 2", dead);
        end
      end
      vectors++;
      if (bus.gnt !== N'(1) << e || bus.active_idx !== 3'(e)) begin
        fails++;
        $display("FAIL rr_order: got gnt=%b idx=%0d, required idx=%0d", bus.gnt, bus.active_idx, e);
      end
      for (int k = 0; k < 3; k++) begin
        bus.in_fifo_data[e*DW +: DW] = word(e, k);
        bus.in_fifo_write[e] = 1'b1;
        bus.in_fifo_send[e] = (k == 2);
        push(word(e, k), 1'b1, k == 2);
        step();
      end
      bus.in_fifo_write[e] = 1'b0;
      bus.in_fifo_send[e] = 1'b0;
    end
    bus.req = '0;
    repeat (4) step();
    vectors++;
    if (bus.drop_cnt !== 16'd0) begin
      fails++;
      $display("FAIL rr_drops: got %0d, required 0", bus.drop_cnt);
    end
  endtask
  task automatic test_single();
    bus.req[2] = 1'b1;
    step();
    vectors++;
    if (bus.gnt !== 5'b00100 || bus.active_idx !== 3'd2) begin
      fails++;
      $display("FAIL single_grant: got gnt=%b idx=%0d, required 00100 idx=2", bus.gnt, bus.active_idx);
    end
    for (int k = 0; k < 4; k++) begin
      bus.in_fifo_data[2*DW +: DW] = word(2, k);
      bus.in_fifo_write[2] = 1'b1;
      bus.in_fifo_send[2] = (k == 3);
      push(word(2, k), 1'b1, k == 3);
      step();
    end
    bus.in_fifo_write = '0;
    bus.in_fifo_send = '0;
    vectors++;
    if (bus.gnt !== '0) begin
      fails++;
      $display("FAIL single_release: got gnt=%b, required 00000", bus.gnt);
    end
    bus.req = '0;
    repeat (3) step();
  endtask
  task automatic test_max_burst();
    int n, m, e;
    bus.req[1] = 1'b1;
    n = 0;
    while (bus.gnt == '0 && n < 20) begin
      step();
      n++;
    end
    vectors++;
    if (bus.gnt !== 5'b00010) begin
      fails++;
      $display("FAIL max_first_grant: got gnt=%b, required 00010", bus.gnt);
    end
    bus.req = '1;
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          bus.in_fifo_data[1*DW +: DW] = word(1, k);
          bus.in_fifo_write[1] = 1'b1;
          if (k < MB) push(word(1, k), 1'b1, k == MB - 1);
          step();
          if (k == MB - 1) bus.req[1] = 1'b0;
        end
        bus.in_fifo_write[1] = 1'b0;
      end
      begin
        for (int j = 0; j < 4; j++) begin
          e = (2 + j) % N;
          m = 0;
          while ((bus.gnt & 5'b11101) == '0 && m < 600) begin
            step();
            m++;
          end
          vectors++;
          if (bus.gnt !== N'(1) << e || bus.active_idx !== 3'(e)) begin
            fails++;
            $display("FAIL max_turns: got gnt=%b idx=%0d, required idx=%0d", bus.gnt, bus.active_idx, e);
          end
          bus.in_fifo_send[e] = 1'b1;
          push('0, 1'b0, 1'b1);
          step();
          bus.in_fifo_send[e] = 1'b0;
          bus.req[e] = 1'b0;
        end
      end
    join
    bus.req[1] = 1'b1;
    n = 0;
    while (bus.gnt == '0 && n < 20) begin
      step();
      n++;
    end
    vectors++;
    if (bus.gnt !== 5'b00010) begin
      fails++;
      $display("FAIL max_regrant: got gnt=%b, required 00010", bus.gnt);
    end
    bus.in_fifo_send[1] = 1'b1;
    push('0, 1'b0, 1'b1);
    step();
    bus.in_fifo_send[1] = 1'b0;
    bus.req = '0;
    repeat (3) step();
    vectors++;
    if (bus.drop_cnt !== 16'd44) begin
      fails++;
      $display("FAIL max_drops: got %0d, required 44", bus.drop_cnt);
    end
  endtask
  task automatic test_timeout();
    int n;
    bus.req[4] = 1'b1;
    n = 0;
    while (bus.gnt == '0 && n < 20) begin
      step();
      n++;
    end
    vectors++;
    if (bus.gnt !== 5'b10000 || bus.timeout_flag !== 1'b0) begin
      fails++;
      $display("FAIL to_grant: got gnt=%b tf=%b, required 10000 tf=0", bus.gnt, bus.timeout_flag);
    end
    push('0, 1'b0, 1'b1);
    n = 0;
    while (!bus.out_fifo_send && n < 1100) begin
      step();
      n++;
    end
    bus.req = '0;
    vectors++;
    if (n !== TO + 1) begin
      fails++;
      $display("FAIL to_cycle: got send at cycle %0d, required %0d", n, TO + 1);
    end
    vectors++;
    if (bus.gnt !== '0 || bus.timeout_flag !== 1'b1 || bus.out_fifo_write !== 1'b0) begin
      fails++;
      $display("FAIL to_release: got gnt=%b tf=%b w=%b, required 00000 tf=1 w=0", bus.gnt, bus.timeout_flag, bus.out_fifo_write);
    end
    repeat (3) step();
  endtask
  task automatic test_saturation();
    int bc;
    bc = 0;
    bus.req[0] = 1'b1;
    for (int c = 0; c < 70000; c++) begin
      bus.in_fifo_data[3*DW +: DW] = word(3, c);
      bus.in_fifo_write[3] = 1'b1;
      if (bus.gnt[0]) begin
        bus.in_fifo_data[0 +: DW] = word(0, c);
        bus.in_fifo_write[0] = 1'b1;
        push(word(0, c), 1'b1, bc == MB - 1);
        bc = (bc == MB - 1) ? 0 : bc + 1;
      end else bus.in_fifo_write[0] = 1'b0;
      step();
      if (c == 999) begin
        vectors++;
        if (bus.drop_cnt !== 16'd1044) begin
          fails++;
          $display("FAIL sat_partial: got %0d, required 1044", bus.drop_cnt);
        end
      end
    end
    bus.in_fifo_write = '0;
    if (bus.gnt[0]) begin
      bus.in_fifo_send[0] = 1'b1;
      push('0, 1'b0, 1'b1);
      step();
      bus.in_fifo_send[0] = 1'b0;
    end
    bus.req = '0;
    repeat (3) step();
    vectors++;
    if (bus.drop_cnt !== 16'hFFFF) begin
      fails++;
      $display("FAIL sat_drops: got %h, required ffff", bus.drop_cnt);
    end
  endtask
  task automatic test_almost_full_reset();
    bus.out_fifo_almost_full = 1'b1;
    bus.req[2] = 1'b1;
    repeat (5) step();
    vectors++;
    if (bus.gnt !== '0) begin
      fails++;
      $display("FAIL af_hold: got gnt=%b, required 00000", bus.gnt);
    end
    bus.out_fifo_almost_full = 1'b0;
    step();
    vectors++;
    if (bus.gnt !== 5'b00100) begin
      fails++;
      $display("FAIL af_grant: got gnt=%b, required 00100", bus.gnt);
    end
    for (int k = 0; k < 2; k++) begin
      bus.in_fifo_data[2*DW +: DW] = word(2, k);
      bus.in_fifo_write[2] = 1'b1;
      push(word(2, k), 1'b1, 1'b0);
      step();
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.gnt, bus.out_fifo_write, bus.out_fifo_send, bus.active_idx, bus.drop_cnt, bus.timeout_flag, bus.out_fifo_data} !== '0) begin
      fails++;
      $display("FAIL rst_mid: got gnt=%b w=%b s=%b idx=%0d drop=%0d tf=%b, required all 0", bus.gnt, bus.out_fifo_write, bus.out_fifo_send, bus.active_idx, bus.drop_cnt, bus.timeout_flag);
    end
    bus.req = '0;
    bus.in_fifo_write = '0;
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();
  endtask
  task automatic test_reset_winner();
    bus.req = '1;
    step();
    vectors++;
    if (bus.gnt !== 5'b00001) begin
      fails++;
      $display("FAIL first_winner: got gnt=%b, required 00001", bus.gnt);
    end
    bus.in_fifo_send[0] = 1'b1;
    push('0, 1'b0, 1'b1);
    step();
    bus.in_fifo_send[0] = 1'b0;
    bus.req = '0;
    repeat (4) step();
    vectors++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: got %0d pending, required 0", sbq.size());
    end
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.req = '0;
    bus.in_fifo_data = '0;
    bus.in_fifo_write = '0;
    bus.in_fifo_send = '0;
    bus.out_fifo_almost_full = 1'b0;
    test_reset();
    test_round_robin();
    test_single();
    test_max_burst();
    test_timeout();
    test_saturation();
    test_almost_full_reset();
    test_reset_winner();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/dma_stream_arbiter.md
# dma_stream_arbiter

Round-robin packet arbiter that shares one 256-bit fifo_stream write port (data/write/send) among the DMA/FIFO subsystems. Each subsystem requests the port, receives an exclusive grant, streams words, and closes its burst with send. The arbiter enforces a maximum burst length and an idle timeout, and counts writes from ungranted sources. It sits between the DMA subsystems and the single downstream stream FIFO.

## Interface
- N_REQ, 5, number of requesters (2..8)
- DATA_W, 256, stream word width
- MAX_BURST, 256, words per grant before a forced release (≥2)
- TIMEOUT, 1023, idle cycles under grant before a forced release (≥1)

- clk_clk  in  1  single clock
- reset_reset  in  1  asynchronous, active-high reset
- req  in  N_REQ  per-requester request level
- gnt  out  N_REQ  one-hot grant, registered
- in_fifo_data  in  N_REQ*DATA_W  requester words; slice i is [i*DATA_W +: DATA_W]
- in_fifo_write  in  N_REQ  word-valid per requester
- in_fifo_send  in  N_REQ  end-of-burst per requester
- out_fifo_data  out  DATA_W  merged stream data
- out_fifo_write  out  1  merged word-valid
- out_fifo_send  out  1  merged end-of-burst
- out_fifo_almost_full  in  1  downstream headroom flag; sampled only when issuing a grant
- active_idx  out  3  index of the granted requester; valid while any gnt bit is set
- drop_cnt  out  16  saturating count of ignored writes
- timeout_flag  out  1  sticky; set by any timeout release

## Operation
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - Applies when any req is high and out_fifo_almost_full is low.
  - Picks the first requester with req high, searching from last_winner+1 with wrap-around.
  - Next cycle: gnt is one-hot, active_idx is set, word_cnt=0, idle_cnt=0, state GRANT.
- GRANT:
  - Forwards the granted requester's data, write and send to the outputs, registered.
  - Each forwarded write increments word_cnt.
  - idle_cnt increments on cycles with no write and clears on a write.
- Release conditions, checked every GRANT cycle. On any of them, go to RELEASE and drop gnt next cycle:
  - (a) in_fifo_send from the granted requester.
  - (b) a write that makes word_cnt == MAX_BURST. out_fifo_send is forced high with that word.
  - (c) idle_cnt reaches TIMEOUT. A standalone send is emitted (write=0, send=1) and timeout_flag is set.
  - (d) req of the granted requester falls without send. A standalone send is emitted, unless that same cycle carries a write that satisfies (b).
- Simultaneous conditions: exactly one out_fifo_send pulse per burst. If send and MAX_BURST coincide, there is one combined send.
- A send without write from the granted requester is forwarded as a standalone send.
- RELEASE: lasts one cycle with gnt all zero. last_winner is updated, then state IDLE.
- Ignored writes: any in_fifo_write from a requester not granted this cycle adds 1 per offending bit to drop_cnt, saturating at 0xFFFF.
- out_fifo_almost_full does not stall a burst in progress. The downstream threshold must leave at least MAX_BURST+2 words of headroom.
- Reset values:
  - gnt=0, out_fifo_*=0, active_idx=0, drop_cnt=0, timeout_flag=0, state IDLE.
  - last_winner=N_REQ-1, so requester 0 wins first.
  - Reset mid-burst truncates the burst with no send emitted.

## Timing
- Grant latency: req seen high in IDLE at cycle t gives gnt at t+1.
- Datapath latency: a word accepted at cycle t appears on out_fifo_* at t+1.
- Inputs are sampled against gnt as registered in the same cycle.
- Turnaround: release condition at t, gnt low at t+1 (RELEASE), IDLE at t+2, next gnt at t+3. That is 2 dead cycles between bursts.
- Writes at t+1 after a send are counted as drops.
- Peak throughput: MAX_BURST words per MAX_BURST+2 cycles under continuous requests.

## Structure
- Package dma_arb_pkg holds:
  - state enum {IDLE, GRANT, RELEASE};
  - default parameter constants;
  - the drop_cnt saturation constant.
- Sub-module rr_pick: combinational round-robin picker with inputs req[N_REQ] and last[2:0], and outputs onehot[N_REQ], idx[2:0] and any.
- The top holds the FSM, counters and output registers.

## Test plan
- Single requester 2 burst of 4 words ending with send on word 4 → gnt[2] at t+1; out_fifo_write for 4 cycles; one send with word 4; gnt low 1 cycle later.
- All 5 req held continuously with 3-word bursts → grant order 0,1,2,3,4,0; 2 dead cycles between bursts; drop_cnt=0.
- Requester 1 streams 300 words with no send, MAX_BURST=256 → send forced on word 256; words 257+ count as drops; requester 1 re-granted only after the others have had their turn.
- Grant held with no writes for TIMEOUT=1023 cycles → standalone send at cycle 1024; timeout_flag=1; gnt released.
- Requester 3 writes while requester 0 is granted, 70000 times → drop_cnt saturates at 0xFFFF; output shows only requester 0's data.
- out_fifo_almost_full high with req pending → no grant. Deassert it → gnt next cycle. Assert reset mid-burst → all outputs 0 immediately, no send.
